// File: rtl/amplitude_scheduler_pkg.sv
// Shared definitions for the amplitude scheduler: scheduler FSM encoding
// and the offset-binary silence constant.
package amplitude_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Silence in offset binary is the MSB-only code; callers cast to their width.
  localparam logic [11:0] SILENCE_12 = 12'h800;

  function automatic logic [31:0] silence_word(input int bits);
    silence_word = 32'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/amp_mult_stage.sv
// Registered single-voice scaler: offset-binary sample times unsigned amplitude,
// keeping the top DATA_BITS of the product, result returned in offset binary.
module amp_mult_stage
  import amplitude_scheduler_pkg::*;
#(
  parameter int DATA_BITS      = 12,
  parameter int AMPLITUDE_BITS = 8,
  parameter int TAG_BITS       = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic [TAG_BITS-1:0]       issue_tag,
  input  logic [DATA_BITS-1:0]      sample,
  input  logic [AMPLITUDE_BITS-1:0] amp,
  output logic                      result_valid,
  output logic [TAG_BITS-1:0]       result_tag,
  output logic [DATA_BITS-1:0]      result
);

  localparam int PROD_BITS = DATA_BITS + AMPLITUDE_BITS;
  localparam logic [DATA_BITS-1:0] SILENCE = DATA_BITS'(silence_word(DATA_BITS));

  logic signed [DATA_BITS-1:0]    sample_signed_s;
  logic signed [AMPLITUDE_BITS:0] amp_signed_s;
  logic signed [PROD_BITS-1:0]    product_s;
  logic [DATA_BITS-1:0]           scaled_s;

  // Signed multiply; the product always fits PROD_BITS since amp is non-negative.
  always_comb begin
    sample_signed_s = $signed({~sample[DATA_BITS-1], sample[DATA_BITS-2:0]});
    amp_signed_s    = $signed({1'b0, amp});
    product_s       = PROD_BITS'(sample_signed_s) * PROD_BITS'(amp_signed_s);
    scaled_s        = {~product_s[PROD_BITS-1], product_s[PROD_BITS-2:AMPLITUDE_BITS]};
  end

  // Output register of the multiplier stage, tag travels with the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      result_tag   <= {TAG_BITS{1'b0}};
      result       <= SILENCE;
    end else begin
      result_valid <= issue_valid;
      if (issue_valid) begin
        result_tag <= issue_tag;
        result     <= scaled_s;
      end
    end
  end

endmodule

// File: rtl/amplitude_scheduler.sv
// Time-shares one registered multiplier across NUM_VOICES voices per frame,
// producing per-voice scaled samples and their average.
module amplitude_scheduler
  import amplitude_scheduler_pkg::*;
#(
  parameter int NUM_VOICES     = 4,
  parameter int DATA_BITS      = 12,
  parameter int AMPLITUDE_BITS = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sample_strobe,
  input  logic [NUM_VOICES*DATA_BITS-1:0]      din,
  input  logic [NUM_VOICES*AMPLITUDE_BITS-1:0] amplitude,
  output logic [NUM_VOICES*DATA_BITS-1:0]      dout,
  output logic [DATA_BITS-1:0]                 mix_out,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overrun
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = DATA_BITS + IDX_W;
  localparam logic [DATA_BITS-1:0] SILENCE = DATA_BITS'(silence_word(DATA_BITS));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  sched_state_e state_r, state_next_s;

  logic [IDX_W-1:0]                      idx_r;
  logic [NUM_VOICES*DATA_BITS-1:0]       din_snap_r;
  logic [NUM_VOICES*AMPLITUDE_BITS-1:0]  amp_snap_r;
  logic [NUM_VOICES*DATA_BITS-1:0]       dout_r;
  logic [DATA_BITS-1:0]                  mix_r;
  logic signed [ACC_W-1:0]               acc_r;
  logic                                  busy_r;
  logic                                  done_r;
  logic                                  overrun_r;

  logic                                  issue_s;
  logic                                  start_s;
  logic [DATA_BITS-1:0]                  issue_din_s;
  logic [AMPLITUDE_BITS-1:0]             issue_amp_s;
  logic                                  prod_valid_s;
  logic [IDX_W-1:0]                      prod_idx_s;
  logic [DATA_BITS-1:0]                  prod_s;
  logic [ACC_W-1:0]                      prod_ext_s;
  logic signed [ACC_W-1:0]               acc_sum_s;
  logic signed [ACC_W-1:0]               mix_shift_s;
  logic [DATA_BITS-1:0]                  mix_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and issue control.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    start_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sample_strobe) begin
          start_s      = 1'b1;
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        issue_s = 1'b1;
        if (idx_r == LAST_IDX) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_DRAIN: state_next_s = ST_DONE;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Operand selection from the snapshot and accumulate/average arithmetic.
  always_comb begin
    issue_din_s = din_snap_r[int'(idx_r)*DATA_BITS +: DATA_BITS];
    issue_amp_s = amp_snap_r[int'(idx_r)*AMPLITUDE_BITS +: AMPLITUDE_BITS];
    prod_ext_s  = {{IDX_W{~prod_s[DATA_BITS-1]}}, ~prod_s[DATA_BITS-1], prod_s[DATA_BITS-2:0]};
    acc_sum_s   = acc_r + $signed(prod_ext_s);
    mix_shift_s = acc_sum_s >>> IDX_W;
    mix_s       = {~mix_shift_s[DATA_BITS-1], mix_shift_s[DATA_BITS-2:0]};
  end

  amp_mult_stage #(
    .DATA_BITS      (DATA_BITS),
    .AMPLITUDE_BITS (AMPLITUDE_BITS),
    .TAG_BITS       (IDX_W)
  ) u_mult (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_s),
    .issue_tag    (idx_r),
    .sample       (issue_din_s),
    .amp          (issue_amp_s),
    .result_valid (prod_valid_s),
    .result_tag   (prod_idx_s),
    .result       (prod_s)
  );

  // Snapshot, voice index, accumulator, result slots and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r      <= {IDX_W{1'b0}};
      din_snap_r <= {(NUM_VOICES*DATA_BITS){1'b0}};
      amp_snap_r <= {(NUM_VOICES*AMPLITUDE_BITS){1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      dout_r     <= {NUM_VOICES{SILENCE}};
      mix_r      <= SILENCE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      busy_r    <= (state_next_s != ST_IDLE);
      done_r    <= (state_r == ST_DRAIN);
      overrun_r <= sample_strobe && (state_r != ST_IDLE);
      if (start_s) begin
        din_snap_r <= din;
        amp_snap_r <= amplitude;
        idx_r      <= {IDX_W{1'b0}};
        acc_r      <= {ACC_W{1'b0}};
      end else begin
        if (issue_s) begin
          idx_r <= idx_r + IDX_W'(1);
        end
        if (prod_valid_s) begin
          acc_r <= acc_sum_s;
          dout_r[int'(prod_idx_s)*DATA_BITS +: DATA_BITS] <= prod_s;
        end
      end
      // The last voice lands in DRAIN, so the average is registered here to
      // be visible together with the done pulse.
      if (state_r == ST_DRAIN) begin
        mix_r <= mix_s;
      end
    end
  end

  assign dout    = dout_r;
  assign mix_out = mix_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_amplitude_scheduler.sv
// Self-checking bench for amplitude_scheduler: directed frames plus randomized
// frames compared against an arithmetic reference model.
module tb_amplitude_scheduler;

  localparam int NV = 4;
  localparam int DB = 12;
  localparam int AB = 8;
  localparam int SIL = 32'h800;

  logic              clk;
  logic              rst_n;
  logic              sample_strobe;
  logic [NV*DB-1:0]  din;
  logic [NV*AB-1:0]  amplitude;
  logic [NV*DB-1:0]  dout;
  logic [DB-1:0]     mix_out;
  logic              busy;
  logic              done;
  logic              overrun;

  int n_checks = 0;
  int n_errors = 0;
  int prev_dout [NV];
  int prev_mix;
  int exp_dout [NV];
  int exp_mix;

  amplitude_scheduler #(
    .NUM_VOICES     (NV),
    .DATA_BITS      (DB),
    .AMPLITUDE_BITS (AB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .din           (din),
    .amplitude     (amplitude),
    .dout          (dout),
    .mix_out       (mix_out),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed sample times amplitude, floor-divided by 2^AB.
  function automatic int scale_voice(input int d, input int a);
    int s;
    s = d - 2048;
    return (s * a) >>> AB;
  endfunction

  task automatic compute_expected(input logic [NV*DB-1:0] d, input logic [NV*AB-1:0] a);
    int sum;
    int sc;
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      sc = scale_voice(int'(d[i*DB +: DB]), int'(a[i*AB +: AB]));
      exp_dout[i] = (sc + 2048) & 32'hFFF;
      sum += sc;
    end
    exp_mix = ((sum >>> 2) + 2048) & 32'hFFF;
  endtask

  task automatic set_silence_model();
    for (int i = 0; i < NV; i++) prev_dout[i] = SIL;
    prev_mix = SIL;
  endtask

  task automatic check_slots(input string tag, input int c, input bit all_new);
    for (int i = 0; i < NV; i++) begin
      if (all_new || c >= 3 + i)
        check_value($sformatf("%s_c%0d_slot%0d", tag, c, i), 32'(dout[i*DB +: DB]), 32'(exp_dout[i]));
      else
        check_value($sformatf("%s_c%0d_slot%0d", tag, c, i), 32'(dout[i*DB +: DB]), 32'(prev_dout[i]));
    end
  endtask

  // One frame with per-cycle checks; optionally perturbs inputs mid-frame.
  task automatic run_frame(input string tag, input logic [NV*DB-1:0] d, input logic [NV*AB-1:0] a,
                           input bit perturb, input logic [NV*DB-1:0] alt_d);
    compute_expected(d, a);
    din = d;
    amplitude = a;
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (perturb && c == 2) begin
        din = alt_d;
        amplitude = ~a;
      end
      check_value($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c <= 6));
      check_value($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(c == 6));
      check_value($sformatf("%s_ovr_c%0d", tag, c), 32'(overrun), 32'd0);
      check_slots(tag, c, 1'b0);
      check_value($sformatf("%s_mix_c%0d", tag, c), 32'(mix_out), 32'(c >= 6 ? exp_mix : prev_mix));
      step();
    end
    for (int i = 0; i < NV; i++) prev_dout[i] = exp_dout[i];
    prev_mix = exp_mix;
  endtask

  initial begin
    logic [NV*DB-1:0] d;
    logic [NV*AB-1:0] a;

    rst_n = 1'b0;
    sample_strobe = 1'b0;
    din = '0;
    amplitude = '0;
    set_silence_model();
    repeat (3) step();
    rst_n = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NV; i++)
        check_value($sformatf("rst_slot%0d", i), 32'(dout[i*DB +: DB]), 32'(SIL));
      check_value("rst_mix", 32'(mix_out), 32'(SIL));
      check_value("rst_busy", 32'(busy), 32'd0);
      check_value("rst_done", 32'(done), 32'd0);
      check_value("rst_ovr", 32'(overrun), 32'd0);
      step();
    end

    // Boundary vector: full scale, half amplitude on zero code, midscale, zero amp.
    run_frame("vec", {12'h123, 12'h800, 12'h000, 12'hFFF}, {8'h00, 8'hFF, 8'h80, 8'hFF}, 1'b0, '0);
    check_value("vec_slot0_abs", 32'(prev_dout[0]), 32'hFF7);
    check_value("vec_slot1_abs", 32'(prev_dout[1]), 32'h400);

    // All voices full scale.
    run_frame("full", {4{12'hFFF}}, {4{8'hFF}}, 1'b0, '0);
    check_value("full_mix_abs", 32'(mix_out), 32'hFF7);

    // Input change mid-frame must not leak into the frame.
    run_frame("snap", {4{12'hFFF}}, {4{8'hFF}}, 1'b1, '0);

    // Strobes during ISSUE and during DONE are overruns.
    d = 48'({$urandom(), $urandom()});
    a = $urandom();
    compute_expected(d, a);
    din = d;
    amplitude = a;
    sample_strobe = 1'b1;
    step();
    for (int c = 1; c <= 9; c++) begin
      sample_strobe = (c == 3 || c == 6);
      if (c == 2) din = ~d;
      check_value($sformatf("ovr_pulse_c%0d", c), 32'(overrun), 32'(c == 4 || c == 7));
      check_value($sformatf("ovr_done_c%0d", c), 32'(done), 32'(c == 6));
      check_value($sformatf("ovr_busy_c%0d", c), 32'(busy), 32'(c <= 6));
      if (c >= 6) begin
        check_slots("ovr", c, 1'b1);
        check_value($sformatf("ovr_mix_c%0d", c), 32'(mix_out), 32'(exp_mix));
      end
      step();
    end
    sample_strobe = 1'b0;
    for (int i = 0; i < NV; i++) prev_dout[i] = exp_dout[i];
    prev_mix = exp_mix;

    // Reset in the middle of a frame aborts it.
    din = {4{12'hFFF}};
    amplitude = {4{8'hFF}};
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_silence_model();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NV; i++)
        check_value($sformatf("abort_slot%0d", i), 32'(dout[i*DB +: DB]), 32'(SIL));
      check_value("abort_mix", 32'(mix_out), 32'(SIL));
      check_value("abort_done", 32'(done), 32'd0);
      check_value("abort_busy", 32'(busy), 32'd0);
      step();
    end
    run_frame("post_abort", {12'h000, 12'hABC, 12'h7FF, 12'h801}, {8'h01, 8'h7F, 8'hFF, 8'hC3}, 1'b0, '0);

    // Randomized frames with random idle gaps and mid-frame input churn.
    for (int f = 0; f < 16; f++) begin
      d = 48'({$urandom(), $urandom()});
      a = $urandom();
      run_frame($sformatf("rnd%0d", f), d, a, f[0], 48'({$urandom(), $urandom()}));
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
